// File: rtl/lzw_out_packer.sv
// Packs variable-width LZW codes LSB-first into bytes and streams them to the
// byte sink through a small FIFO. Busy holds off the controller while packing.
module lzw_out_packer #(
    parameter int CODE_W     = 9,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RequestOutBuffer,
    input  logic [CODE_W-1:0] CodeIn,
    input  logic              CloseBuffer,
    input  logic              OutReady,
    output logic [7:0]        OutByte,
    output logic              OutValid,
    output logic              Busy,
    output logic              BufferClosed,
    output logic              Overflow
);
    localparam int ACC_W = CODE_W + 7;
    localparam int CNT_W = $clog2(CODE_W + 8);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PACK   = 3'd1;
    localparam logic [2:0] FLUSH  = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] CLOSED = 3'd4;

    localparam logic [CNT_W-1:0] EIGHT     = CNT_W'(8);
    localparam logic [CNT_W-1:0] CODE_BITS = CNT_W'(CODE_W);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   ONE_CNT   = (PTR_W+1)'(1);

    logic [2:0]       state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             close_pend, close_pend_nxt;
    logic             push, pop, fifo_full;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;

    assign fifo_full    = (count == FULL_CNT);
    assign OutValid     = (count != '0);
    assign pop          = OutValid && OutReady;
    assign OutByte      = OutValid ? mem[rd_ptr] : 8'h00;
    assign Busy         = (state != IDLE);
    assign BufferClosed = (state == CLOSED);

    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        cnt_nxt        = cnt;
        close_pend_nxt = close_pend;
        push           = 1'b0;
        case (state)
            IDLE: begin
                if (RequestOutBuffer) begin
                    acc_nxt        = acc | (ACC_W'(CodeIn) << cnt);
                    cnt_nxt        = cnt + CODE_BITS;
                    close_pend_nxt = CloseBuffer;
                    state_nxt      = PACK;
                end else if (CloseBuffer) begin
                    state_nxt = FLUSH;
                end
            end
            PACK: begin
                // A close arriving on the last pack cycle still routes to FLUSH.
                close_pend_nxt = close_pend | CloseBuffer;
                if (cnt >= EIGHT && !fifo_full) begin
                    push    = 1'b1;
                    acc_nxt = acc >> 8;
                    cnt_nxt = cnt - EIGHT;
                end
                if (cnt_nxt < EIGHT)
                    state_nxt = close_pend_nxt ? FLUSH : IDLE;
            end
            FLUSH: begin
                close_pend_nxt = 1'b0;
                if (cnt == '0) begin
                    state_nxt = DRAIN;
                end else if (!fifo_full) begin
                    push      = 1'b1;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Close on the pop of the last byte so BufferClosed follows it directly.
                if (count == '0 || (count == ONE_CNT && pop))
                    state_nxt = CLOSED;
            end
            CLOSED: state_nxt = CLOSED;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            close_pend <= 1'b0;
            Overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            cnt        <= cnt_nxt;
            close_pend <= close_pend_nxt;
            if (RequestOutBuffer && Busy)
                Overflow <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + ONE_CNT;
            else if (pop && !push)
                count <= count - ONE_CNT;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= acc[7:0];
    end
endmodule
